// File: rtl/fifo_output_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// fifo_output_scheduler_pkg
//   Shared definitions for the router output scheduler: downstream buffer
//   depth (default credit count), FSM state encodings and a clog2 helper
//   so every module sizes its counters the same way.
// ---------------------------------------------------------------------------
package fifo_output_scheduler_pkg;

    // Downstream router input buffer depth in flits.
    localparam int BUFFER_DEPTH = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
//   Combinational round-robin picker. Searches req starting at index
//   `start` and wrapping modulo N; the first set bit wins.
//   Ports:
//     req    in  N      request vector
//     start  in  PTR_W  first index to consider (must be < N)
//     grant  out N      one-hot winner (zero when no request)
//     idx    out PTR_W  binary index of the winner
//     valid  out 1      any request present
// ---------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] start,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    int pos;

    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        grant = '0;
        idx   = '0;
        pos   = 0;
        valid = |req;
        for (int off = N - 1; off >= 0; off--) begin
            pos = (int'(start) + off) % N;
            if (req[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                idx        = PTR_W'(pos);
            end
        end
    end

endmodule

// File: rtl/fifo_output_scheduler.sv
// ---------------------------------------------------------------------------
// fifo_output_scheduler
//   Shares one router output channel between NUM_REQ input FIFOs. A
//   round-robin winner is granted for a whole packet of PACKET_FLITS flits;
//   one flit is popped per cycle while the granted FIFO is non-empty and a
//   downstream credit is available.
//   Ports:
//     clk                in  1       rising-edge clock
//     reset              in  1       synchronous, active-low
//     fifo_empty_din     in  NUM_REQ per-FIFO empty flags
//     credit_return_din  in  1       downstream freed one slot
//     read_strobe_dout   out NUM_REQ one-hot pop strobe
//     grant_dout         out NUM_REQ registered one-hot grant (mux select)
//     flit_valid_dout    out 1       downstream write strobe
//     credit_count_dout  out CRD_W   current credit count
//     credit_error_dout  out 1       sticky: return arrived at full credits
// ---------------------------------------------------------------------------
module fifo_output_scheduler
    import fifo_output_scheduler_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int PACKET_FLITS = 4,
    parameter  int CREDITS      = BUFFER_DEPTH,
    localparam int CRD_W        = clog2(CREDITS + 1),
    localparam int PTR_W        = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ),
    localparam int CNT_W        = clog2(PACKET_FLITS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] fifo_empty_din,
    input  logic               credit_return_din,
    output logic [NUM_REQ-1:0] read_strobe_dout,
    output logic [NUM_REQ-1:0] grant_dout,
    output logic               flit_valid_dout,
    output logic [CRD_W-1:0]   credit_count_dout,
    output logic               credit_error_dout
);

    localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(PACKET_FLITS - 1);
    localparam logic [CRD_W-1:0] FULL_CRD  = CRD_W'(CREDITS);

    logic [0:0]         state_q,  state_d;
    logic [NUM_REQ-1:0] grant_q,  grant_d;
    logic [PTR_W-1:0]   gidx_q,   gidx_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   flit_q,   flit_d;
    logic [CRD_W-1:0]   credit_q, credit_d;
    logic               cerr_q,   cerr_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               pop;

    rr_priority_picker #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req   (~fifo_empty_din),
        .start (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Strobe is gated by reset so an abandoned packet loses no flit in the
    // reset cycle itself.
    always_comb begin
        read_strobe_dout = '0;
        if (reset && state_q == ST_XFER && credit_q != '0)
            read_strobe_dout = grant_q & ~fifo_empty_din;
    end

    assign pop = |read_strobe_dout;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        flit_d   = flit_q;
        credit_d = credit_q;
        cerr_d   = cerr_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_grant;
                    gidx_d  = pick_idx;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (pop) begin
                    if (flit_q == LAST_FLIT) begin
                        flit_d   = '0;
                        rr_ptr_d = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                        grant_d  = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        flit_d = flit_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pop and return together cancel out.
        if (pop && !credit_return_din) begin
            credit_d = credit_q - 1'b1;
        end else if (credit_return_din && !pop) begin
            if (credit_q == FULL_CRD) cerr_d = 1'b1;
            else                      credit_d = credit_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            flit_q   <= '0;
            credit_q <= FULL_CRD;
            cerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            flit_q   <= flit_d;
            credit_q <= credit_d;
            cerr_q   <= cerr_d;
        end
    end

    assign grant_dout        = grant_q;
    assign flit_valid_dout   = pop;
    assign credit_count_dout = credit_q;
    assign credit_error_dout = cerr_q;

endmodule

// File: tb/tb_fifo_output_scheduler.sv
module tb_fifo_output_scheduler;

    localparam int N   = 4;
    localparam int PF  = 4;
    localparam int CRD = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] fifo_empty_din;
    logic         credit_return_din;
    logic [N-1:0] read_strobe_dout;
    logic [N-1:0] grant_dout;
    logic         flit_valid_dout;
    logic [2:0]   credit_count_dout;
    logic         credit_error_dout;

    int checks   = 0;
    int failures = 0;

    fifo_output_scheduler #(
        .NUM_REQ      (N),
        .PACKET_FLITS (PF),
        .CREDITS      (CRD)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_empty_din    (fifo_empty_din),
        .credit_return_din (credit_return_din),
        .read_strobe_dout  (read_strobe_dout),
        .grant_dout        (grant_dout),
        .flit_valid_dout   (flit_valid_dout),
        .credit_count_dout (credit_count_dout),
        .credit_error_dout (credit_error_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Packet ownership, flit count, credit pool and rr start index as plain ints.
    bit m_valid = 0;
    bit m_busy;
    int m_owner, m_done, m_cred, m_ptr;
    bit m_err;

    always @(negedge clk) begin
        bit          can_pop, was_busy;
        logic [N-1:0] e_grant, e_strb;
        e_grant = '0;
        e_strb  = '0;
        can_pop = m_valid && m_busy && reset && !fifo_empty_din[m_owner] && m_cred > 0;
        if (m_valid) begin
            if (m_busy)  e_grant[m_owner] = 1'b1;
            if (can_pop) e_strb[m_owner]  = 1'b1;
            chk("m_grant",  grant_dout,        e_grant);
            chk("m_strobe", read_strobe_dout,  e_strb);
            chk("m_fvalid", flit_valid_dout,   can_pop);
            chk("m_credit", credit_count_dout, m_cred);
            chk("m_cerr",   credit_error_dout, m_err);
        end
        // advance to the state after the coming rising edge
        if (!reset) begin
            m_valid = 1; m_busy = 0; m_owner = 0; m_done = 0;
            m_cred = CRD; m_ptr = 0; m_err = 0;
        end else if (m_valid) begin
            was_busy = m_busy;
            if (can_pop) begin
                m_done++;
                if (m_done == PF) begin
                    m_done = 0; m_busy = 0; m_ptr = (m_owner + 1) % N;
                end
            end
            if (!was_busy) begin
                for (int j = 0; j < N; j++) begin
                    if (!m_busy && !fifo_empty_din[(m_ptr + j) % N]) begin
                        m_busy = 1; m_owner = (m_ptr + j) % N;
                    end
                end
            end
            if (can_pop && !credit_return_din) m_cred--;
            else if (credit_return_din && !can_pop) begin
                if (m_cred == CRD) m_err = 1;
                else m_cred++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic [N-1:0] e, input logic ret);
        @(posedge clk); #1;
        reset = r; fifo_empty_din = e; credit_return_din = ret;
        @(negedge clk); #1;
    endtask

    initial begin
        int ret_pct, emp_pct;
        logic [N-1:0] e;
        reset = 1'b0; fifo_empty_din = '1; credit_return_din = 1'b0;
        repeat (2) @(posedge clk);
        cyc(1, 4'b1111, 0);
        chk("rst_grant",  grant_dout, 0);
        chk("rst_credit", credit_count_dout, CRD);
        chk("rst_cerr",   credit_error_dout, 0);
        chk("rst_strobe", read_strobe_dout, 0);

        // single packet from FIFO1
        cyc(1, 4'b1101, 0);
        chk("sp_idle_grant", grant_dout, 0);
        cyc(1, 4'b1101, 0);
        chk("sp_grant", grant_dout, 4'b0010);
        chk("sp_strobe1", read_strobe_dout, 4'b0010);
        repeat (3) cyc(1, 4'b1101, 0);
        chk("sp_strobe4", read_strobe_dout, 4'b0010);
        cyc(1, 4'b1101, 0);
        chk("sp_release", grant_dout, 0);
        chk("sp_credit0", credit_count_dout, 0);
        // credit stall: re-granted but no strobe; one return -> one pop
        cyc(1, 4'b1101, 1);
        chk("cs_grant", grant_dout, 4'b0010);
        chk("cs_nostrb", read_strobe_dout, 0);
        cyc(1, 4'b1101, 0);
        chk("cs_credit1", credit_count_dout, 1);
        chk("cs_onepop", read_strobe_dout, 4'b0010);
        cyc(1, 4'b1101, 0);
        chk("cs_stall2", read_strobe_dout, 0);

        // reset mid-packet, arbitration restarts at FIFO0
        cyc(0, 4'b1101, 0);
        chk("rm_nopop", read_strobe_dout, 0);
        cyc(1, 4'b0000, 0);
        chk("rm_grant0", grant_dout, 0);
        chk("rm_credit", credit_count_dout, CRD);
        cyc(1, 4'b0000, 1);
        chk("rm_fifo0", grant_dout, 4'b0001);
        // pop + return same cycle keeps credits; return at full sets error
        cyc(1, 4'b1111, 1);
        chk("pr_credit", credit_count_dout, CRD);
        cyc(1, 4'b1111, 0);
        chk("ce_set", credit_error_dout, 1);
        cyc(1, 4'b1111, 0);
        chk("ce_sticky", credit_error_dout, 1);

        // randomized phases
        for (int ph = 0; ph < 30; ph++) begin
            ret_pct = $urandom_range(0, 80);
            emp_pct = $urandom_range(0, 60);
            for (int c = 0; c < 100; c++) begin
                for (int b = 0; b < N; b++) e[b] = ($urandom_range(0, 99) < emp_pct);
                cyc(($urandom_range(0, 299) != 0), e,
                    ($urandom_range(0, 99) < ret_pct));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
